// File: rtl/solver_stream_source.sv
// ---------------------------------------------------------------------------
// solver_stream_source
//   Walks a video frame in raster order, issues one multi_solver read per
//   pixel and presents the results as an Avalon-ST source.  The fixed read
//   latency is covered by a tag pipeline.  A show-ahead FIFO absorbs sink
//   backpressure, and a credit check keeps that FIFO from overflowing.
//
// Ports
//   clock, reset_n        system clock, asynchronous active-low reset
//   enable                stream frames back-to-back while high
//   rd_solver_id, rd_addr solver select / word address to multi_solver
//   rd_data               solver result, valid RD_LATENCY clocks later
//   src_ready             sink ready
//   src_valid/sop/eop     Avalon-ST beat qualifiers
//   src_data              {rd_data, rd_data}
//   frame_done            one-clock pulse after the EOP beat is accepted
//   busy                  high while a frame is being issued or drained
// ---------------------------------------------------------------------------
module solver_stream_source #(
  parameter int NUM_SOLVERS = 29,
  parameter int WIDTH       = 640,
  parameter int HEIGHT      = 480,
  parameter int RD_LATENCY  = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        enable,
  output logic [5:0]  rd_solver_id,
  output logic [18:0] rd_addr,
  input  logic [3:0]  rd_data,
  input  logic        src_ready,
  output logic        src_valid,
  output logic        src_sop,
  output logic        src_eop,
  output logic [7:0]  src_data,
  output logic        frame_done,
  output logic        busy
);

  localparam int XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + RD_LATENCY + 1) + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t                state_r;
  logic [5:0]            sid_r;
  logic [18:0]           addr_r;
  logic [XW-1:0]         x_r;
  logic [YW-1:0]         y_r;
  logic                  frame_done_r;
  logic                  busy_r;

  logic [RD_LATENCY-1:0] tag_v_r;
  logic [RD_LATENCY-1:0] tag_sop_r;
  logic [RD_LATENCY-1:0] tag_eop_r;

  // FIFO entry layout: {sop, eop, data[3:0]}
  logic [5:0]            fifo_mem_r [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_r;
  logic [PW-1:0]         rd_ptr_r;
  logic [CW-1:0]         count_r;

  logic [CW-1:0]         inflight_s;
  logic                  issue_s;
  logic                  first_pix_s;
  logic                  last_pix_s;
  logic                  wr_s;
  logic                  pop_s;
  logic [5:0]            head_s;

  // Wrap a FIFO pointer at FIFO_DEPTH (depth need not be a power of two).
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
    if (ptr == PW'(FIFO_DEPTH - 1)) begin
      return {PW{1'b0}};
    end else begin
      return ptr + PW'(1);
    end
  endfunction

  // Count reads still in flight through the tag pipeline.
  always_comb begin
    inflight_s = {CW{1'b0}};
    for (int i = 0; i < RD_LATENCY; i++) begin
      inflight_s = inflight_s + CW'(tag_v_r[i]);
    end
  end

  // A read is issued only while the FIFO can hold every outstanding result.
  assign issue_s     = (state_r == ST_RUN) &&
                       ((count_r + inflight_s) < CW'(FIFO_DEPTH));
  assign first_pix_s = (x_r == {XW{1'b0}}) && (y_r == {YW{1'b0}});
  assign last_pix_s  = (x_r == XW'(WIDTH - 1)) && (y_r == YW'(HEIGHT - 1));
  assign wr_s        = tag_v_r[RD_LATENCY-1];
  assign pop_s       = (count_r != {CW{1'b0}}) && src_ready;
  assign head_s      = fifo_mem_r[rd_ptr_r];

  assign rd_solver_id = sid_r;
  assign rd_addr      = addr_r;
  assign src_valid    = (count_r != {CW{1'b0}});
  assign src_sop      = src_valid & head_s[5];
  assign src_eop      = src_valid & head_s[4];
  assign src_data     = src_valid ? {head_s[3:0], head_s[3:0]} : 8'h00;
  assign frame_done   = frame_done_r;
  assign busy         = busy_r;

  // Frame FSM together with the raster / solver address counters.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= ST_IDLE;
      sid_r        <= 6'd0;
      addr_r       <= 19'd0;
      x_r          <= {XW{1'b0}};
      y_r          <= {YW{1'b0}};
      frame_done_r <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      frame_done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (enable) begin
            sid_r   <= 6'd0;
            addr_r  <= 19'd0;
            x_r     <= {XW{1'b0}};
            y_r     <= {YW{1'b0}};
            state_r <= ST_RUN;
            busy_r  <= 1'b1;
          end else begin
            busy_r  <= 1'b0;
          end
        end
        ST_RUN: begin
          if (issue_s) begin
            if (last_pix_s) begin
              // Park all counters at pixel 0 so the next frame starts clean.
              sid_r   <= 6'd0;
              addr_r  <= 19'd0;
              x_r     <= {XW{1'b0}};
              y_r     <= {YW{1'b0}};
              state_r <= ST_DRAIN;
            end else begin
              if (sid_r == 6'(NUM_SOLVERS - 1)) begin
                sid_r  <= 6'd0;
                addr_r <= addr_r + 19'd1;
              end else begin
                sid_r  <= sid_r + 6'd1;
              end
              if (x_r == XW'(WIDTH - 1)) begin
                x_r <= {XW{1'b0}};
                y_r <= y_r + YW'(1);
              end else begin
                x_r <= x_r + XW'(1);
              end
            end
          end
        end
        ST_DRAIN: begin
          if (pop_s && head_s[4]) begin
            frame_done_r <= 1'b1;
            state_r      <= ST_IDLE;
            busy_r       <= 1'b0;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  // Tag pipeline: one slot per clock of read latency.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tag_v_r   <= {RD_LATENCY{1'b0}};
      tag_sop_r <= {RD_LATENCY{1'b0}};
      tag_eop_r <= {RD_LATENCY{1'b0}};
    end else begin
      for (int i = RD_LATENCY - 1; i > 0; i--) begin
        tag_v_r[i]   <= tag_v_r[i-1];
        tag_sop_r[i] <= tag_sop_r[i-1];
        tag_eop_r[i] <= tag_eop_r[i-1];
      end
      tag_v_r[0]   <= issue_s;
      tag_sop_r[0] <= issue_s & first_pix_s;
      tag_eop_r[0] <= issue_s & last_pix_s;
    end
  end

  // Show-ahead output FIFO; push from the tag pipeline, pop on handshake.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem_r[i] <= 6'd0;
      end
    end else begin
      if (wr_s) begin
        fifo_mem_r[wr_ptr_r] <= {tag_sop_r[RD_LATENCY-1],
                                 tag_eop_r[RD_LATENCY-1], rd_data};
        wr_ptr_r             <= ptr_inc(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      case ({wr_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule
